// File: rtl/i_mem_read_arbiter.sv
// Two-master AXI read arbiter: I-cache refill (master 0, priority) and stream-buffer
// prefetch (master 1, starvation-guarded) share one memory read port, one burst at a time.
module i_mem_read_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int LEN_WIDTH    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [LEN_WIDTH-1:0]  m0_arlen,
    input  logic [ID_WIDTH-1:0]   m0_arid,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [ID_WIDTH-1:0]   m0_rid,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,

    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [LEN_WIDTH-1:0]  m1_arlen,
    input  logic [ID_WIDTH-1:0]   m1_arid,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ID_WIDTH-1:0]   m1_rid,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,

    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [LEN_WIDTH-1:0]  s_arlen,
    output logic [ID_WIDTH-1:0]   s_arid,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [ID_WIDTH-1:0]   s_rid,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,

    output logic                  grant,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [LEN_WIDTH-1:0]  lat_len;
    logic [ID_WIDTH-1:0]   lat_id;
    // One extra bit so an overrunning burst keeps counting past arlen instead of wrapping.
    logic [LEN_WIDTH:0]    beat_cnt;
    logic [STARVE_W-1:0]   starve_cnt;

    logic pick_m1;
    logic r_hs;
    logic rid_bad;
    logic overrun;
    logic early_last;

    assign pick_m1    = m1_arvalid && (!m0_arvalid || (starve_cnt == STARVE_MAX));
    assign r_hs       = s_rvalid && s_rready;
    assign rid_bad    = (s_rid != lat_id);
    assign overrun    = (beat_cnt == {1'b0, lat_len}) && !s_rlast;
    assign early_last = s_rlast && (beat_cnt < {1'b0, lat_len});

    // NOTE: every register here is written with <= so all updates see pre-edge values;
    // mixing in blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            busy       <= 1'b0;
            s_arvalid  <= 1'b0;
            starve_cnt <= '0;
            beat_cnt   <= '0;
            lat_addr   <= '0;
            lat_len    <= '0;
            lat_id     <= '0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        state     <= ADDR;
                        busy      <= 1'b1;
                        s_arvalid <= 1'b1;
                        grant     <= pick_m1;
                        lat_addr  <= pick_m1 ? m1_araddr : m0_araddr;
                        lat_len   <= pick_m1 ? m1_arlen  : m0_arlen;
                        lat_id    <= pick_m1 ? m1_arid   : m0_arid;
                        // Only a demand win over a waiting prefetch counts toward starvation.
                        if (pick_m1 || !m1_arvalid) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end

                ADDR: begin
                    if (s_arready) begin
                        state     <= DATA;
                        s_arvalid <= 1'b0;
                        beat_cnt  <= '0;
                    end
                end

                DATA: begin
                    if (r_hs) begin
                        if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (rid_bad || overrun || early_last) begin
                            proto_err <= 1'b1;
                        end
                        if (s_rlast) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    s_arvalid <= 1'b0;
                end
            endcase
        end
    end

    assign s_araddr = lat_addr;
    assign s_arlen  = lat_len;
    assign s_arid   = lat_id;

    // Data and ID buses fan out to both masters; only valid/last are steered.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_rid   = s_rid;
    assign m1_rid   = s_rid;

    // NOTE: each output gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rlast   = 1'b0;
        m1_rlast   = 1'b0;
        s_rready   = 1'b0;
        if (state == ADDR) begin
            if (grant) begin
                m1_arready = s_arready;
            end else begin
                m0_arready = s_arready;
            end
        end
        if (state == DATA) begin
            if (grant) begin
                m1_rvalid = s_rvalid;
                m1_rlast  = s_rlast;
                s_rready  = m1_rready;
            end else begin
                m0_rvalid = s_rvalid;
                m0_rlast  = s_rlast;
                s_rready  = m0_rready;
            end
        end
    end

endmodule
